// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared constants and helpers for the RAM-backed FIFO controller.
// Holds the depth derivation and the output buffer size.
package ram_fifo_ctrl_pkg;

  localparam int OBUF_DEPTH = 2;

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/ram_fifo_obuf.sv
// Two-entry output buffer in FIFO order; e0 is always the head.
// Ports: clk, rst, push/push_data, pop, valid, data, count.
module ram_fifo_obuf
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [1:0]            count
);

  localparam logic [1:0] FULL = 2'(OBUF_DEPTH);

  logic [DATA_WIDTH-1:0] e0;
  logic [DATA_WIDTH-1:0] e1;
  logic [1:0]            cnt;
  logic                  do_pop;

  assign do_pop = pop && (cnt != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0  <= '0;
      e1  <= '0;
      cnt <= 2'd0;
    end else begin
      unique case ({push, do_pop})
        2'b10: begin
          if (cnt == 2'd0) e0 <= push_data;
          else             e1 <= push_data;
          if (cnt != FULL) cnt <= cnt + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          cnt <= cnt - 2'd1;
        end
        2'b11: begin
          // Pop and capture together: occupancy unchanged.
          if (cnt == 2'd1) begin
            e0 <= push_data;
          end else begin
            e0 <= e1;
            e1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign valid = (cnt != 2'd0);
  assign data  = e0;
  assign count = cnt;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller over a single-port RAM with a 2-word output buffer.
// Ports: in_* upstream, out_* downstream, ram_* RAM side, mem_count.
module ram_fifo_ctrl
  import ram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out,
  output logic [ADDR_WIDTH:0]   mem_count
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [1:0] OB_MAX = 2'(OBUF_DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  pri;
  logic                  rd_inflight;
  logic [1:0]            obuf_cnt;
  logic                  wr_req;
  logic                  rd_req;
  logic                  wr_gnt;
  logic                  rd_gnt;

  assign wr_req = in_valid && (mem_count < FULL);
  // In-flight read counts as occupied so the buffer never overflows.
  assign rd_req = (mem_count != '0) &&
                  ((obuf_cnt + {1'b0, rd_inflight}) < OB_MAX);

  assign wr_gnt = !rst && wr_req && (!rd_req || !pri);
  assign rd_gnt = !rst && rd_req && (!wr_req || pri);

  assign in_ready    = wr_gnt;
  assign ram_we      = wr_gnt;
  assign ram_addr    = wr_gnt ? wr_ptr : rd_ptr;
  assign ram_data_in = in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      mem_count   <= '0;
      rd_inflight <= 1'b0;
      pri         <= 1'b0;
    end else begin
      rd_inflight <= rd_gnt;
      if (wr_req && rd_req) pri <= ~pri;
      if (wr_gnt) begin
        wr_ptr    <= wr_ptr + 1'b1;
        mem_count <= mem_count + 1'b1;
      end else if (rd_gnt) begin
        rd_ptr    <= rd_ptr + 1'b1;
        mem_count <= mem_count - 1'b1;
      end
    end
  end

  ram_fifo_obuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_obuf (
    .clk      (clk),
    .rst      (rst),
    .push     (rd_inflight),
    .push_data(ram_data_out),
    .pop      (out_ready),
    .valid    (out_valid),
    .data     (out_data),
    .count    (obuf_cnt)
  );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a RAM model and queue scoreboard.
// Directed scenarios plus random traffic at ADDR_WIDTH=2.
module tb_ram_fifo_ctrl;
  localparam int DW = 8;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out = '0;
  logic [AW:0]   mem_count;

  always #5 clk = ~clk;

  ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out), .mem_count(mem_count)
  );

  logic [DW-1:0] ram [4];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_data_in;
    ram_data_out <= ram[ram_addr];
  end

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] model[$];
  int            wcount = 0;
  int            acc = 0;
  logic          we_prev = 1'b0;
  logic [AW:0]   mc_prev = '0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [DW-1:0] d,
                      input logic r);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    #1;
    if (we_prev) chk("we_no_rd", 32'(mem_count), 32'(mc_prev) + 1);
    chk("mc_max", 32'(mem_count <= 3'd4), 1);
    if (mem_count == 3'd4) chk("full_block", 32'(in_ready), 0);
    chk("we_eq_acc", 32'(ram_we), 32'(in_valid && in_ready));
    if (ram_we) chk("wr_addr", 32'(ram_addr), wcount % 4);
    if (model.size() == 0) begin
      chk("empty_ov", 32'(out_valid), 0);
      chk("empty_mc", 32'(mem_count), 0);
    end
    if (out_valid && out_ready) begin
      chk("pop_nonempty", 32'(model.size() > 0), 1);
      if (model.size() > 0) chk("out_data", 32'(out_data), 32'(model.pop_front()));
    end
    if (in_valid && in_ready) begin
      model.push_back(in_data);
      wcount++;
      acc++;
    end
    we_prev = ram_we;
    mc_prev = mem_count;
  endtask

  task automatic push_one(input logic [DW-1:0] d, input logic r);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      step(1'b1, d, r);
      got = in_valid && in_ready;
    end
    chk("push_accepted", 32'(got), 1);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b1);
    chk("drain_empty", model.size(), 0);
    chk("drain_ov", 32'(out_valid), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic          got;
    logic [DW-1:0] first;

    // Reset state, with in_valid high to show no write leaks through.
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h5a; out_ready = 1'b1;
    #12;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_mem_count", 32'(mem_count), 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b0;

    // Single word latency.
    step(1'b1, 8'h11, 1'b1);
    chk("lat_we", 32'(ram_we), 1);
    chk("lat_addr", 32'(ram_addr), 0);
    step(1'b0, '0, 1'b1);
    chk("lat_n1", 32'(out_valid), 0);
    step(1'b0, '0, 1'b1);
    chk("lat_n1b", 32'(out_valid), 0);
    step(1'b0, '0, 1'b1);
    chk("lat_n2_valid", 32'(out_valid), 1);
    chk("lat_n2_data", 32'(out_data), 32'h11);
    drain(4);

    // Fill with the consumer stalled: six words fit, the seventh waits.
    acc = 0;
    for (int i = 1; i <= 7; i++) begin
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        step(1'b1, 8'(i), 1'b0);
        got = in_valid && in_ready;
      end
    end
    chk("fill_acc", acc, 6);
    chk("fill_mc", 32'(mem_count), 4);
    chk("fill_ir", 32'(in_ready), 0);
    chk("fill_head", 32'(out_data), 1);
    drain(20);

    // Continuous traffic both sides: write/read alternate.
    acc = 0;
    for (int i = 0; i < 40; i++) step(1'b1, 8'($urandom), 1'b1);
    chk("stream_rate", 32'(acc >= 16), 1);
    drain(15);

    // Push/pop pairs, wrapping the pointers.
    for (int i = 0; i < 10; i++) begin
      push_one(8'($urandom), 1'b1);
      for (int k = 0; k < 10 && model.size() != 0; k++)
        step(1'b0, '0, 1'b1);
      chk("pair_done", model.size(), 0);
    end

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step(1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0));
    drain(20);

    // Async reset mid-burst with three words stored.
    for (int i = 0; i < 3; i++) push_one(8'(8'h30 + i), 1'b0);
    step(1'b1, 8'h77, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_in_ready", 32'(in_ready), 0);
    chk("arst_out_valid", 32'(out_valid), 0);
    chk("arst_ram_we", 32'(ram_we), 0);
    chk("arst_out_data", 32'(out_data), 0);
    chk("arst_mem_count", 32'(mem_count), 0);
    model.delete();
    wcount = 0;
    we_prev = 1'b0;
    @(negedge clk);
    #1;
    chk("arst_hold_we", 32'(ram_we), 0);
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    push_one(8'ha5, 1'b1);
    got = 1'b0;
    first = '0;
    for (int k = 0; k < 8 && !got; k++) begin
      step(1'b0, '0, 1'b1);
      if (out_valid) begin
        got = 1'b1;
        first = out_data;
      end
    end
    chk("post_rst_seen", 32'(got), 1);
    chk("post_rst_first", 32'(first), 32'ha5);
    drain(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
